// File: rtl/cluster_periph_demux.sv
// cluster_periph_demux: per-core address demux onto the cluster peripheral slave plugs, in-order responses, error absorb for unmapped slots
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   data_req/add/wen/wdata/be_i, data_gnt_o       core request side
//   data_r_valid/rdata/opc_o                      core response side
//   per_req_o (slot-selective), per_add/wen/wdata/be_o (broadcast), per_gnt_i, per_r_valid/rdata/opc_i   slave plugs
//   busy_o                 transactions outstanding
module cluster_periph_demux #(
  parameter int NB_SLAVES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH = DATA_WIDTH/8,
  parameter int SLOT_LSB = 10,
  parameter int SLOT_BITS = 4,
  parameter logic [NB_SLAVES-1:0] UNMAPPED_MASK = 8'b0000_1000,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADACCE5
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            data_req_i,
  input  logic [ADDR_WIDTH-1:0]           data_add_i,
  input  logic                            data_wen_i,
  input  logic [DATA_WIDTH-1:0]           data_wdata_i,
  input  logic [BE_WIDTH-1:0]             data_be_i,
  output logic                            data_gnt_o,
  output logic                            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
  output logic                            data_r_opc_o,
  output logic [NB_SLAVES-1:0]            per_req_o,
  output logic [NB_SLAVES*ADDR_WIDTH-1:0] per_add_o,
  output logic [NB_SLAVES-1:0]            per_wen_o,
  output logic [NB_SLAVES*DATA_WIDTH-1:0] per_wdata_o,
  output logic [NB_SLAVES*BE_WIDTH-1:0]   per_be_o,
  input  logic [NB_SLAVES-1:0]            per_gnt_i,
  input  logic [NB_SLAVES-1:0]            per_r_valid_i,
  input  logic [NB_SLAVES*DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic [NB_SLAVES-1:0]            per_r_opc_i,
  output logic                            busy_o
);
  localparam int SW = NB_SLAVES > 1 ? $clog2(NB_SLAVES) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [SLOT_BITS-1:0] slot;
  logic [SW-1:0] tgt_idx, cur_idx;
  logic tgt_err, cur_err, err_pend, allowed, fwd_slv;
  logic [CW-1:0] cnt;
  assign slot = data_add_i[SLOT_LSB +: SLOT_BITS];
  assign tgt_idx = slot[SW-1:0];
  assign tgt_err = (32'(slot) >= NB_SLAVES) || UNMAPPED_MASK[tgt_idx];
  // a target switch is only possible once every outstanding response has returned
  assign allowed = (cnt == '0) ||
                   ((tgt_err == cur_err) && (tgt_err || tgt_idx == cur_idx) && cnt < CW'(MAX_OUTSTANDING));
  assign per_req_o = (data_req_i && allowed && !tgt_err) ? NB_SLAVES'(1) << tgt_idx : '0;
  assign data_gnt_o = tgt_err ? data_req_i && allowed : per_req_o[tgt_idx] && per_gnt_i[tgt_idx];
  assign per_add_o = {NB_SLAVES{data_add_i}};
  assign per_wen_o = {NB_SLAVES{data_wen_i}};
  assign per_wdata_o = {NB_SLAVES{data_wdata_i}};
  assign per_be_o = {NB_SLAVES{data_be_i}};
  // only the slave currently owning the outstanding transactions may respond
  assign fwd_slv = (cnt != '0) && !cur_err && per_r_valid_i[cur_idx];
  assign data_r_valid_o = err_pend || fwd_slv;
  assign data_r_opc_o = err_pend || (fwd_slv && per_r_opc_i[cur_idx]);
  assign data_r_rdata_o = err_pend ? ERR_RDATA :
                          fwd_slv ? per_r_rdata_i[cur_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy_o = cnt != '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt <= '0;
      cur_idx <= '0;
      cur_err <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      cnt <= cnt + CW'(data_gnt_o) - CW'(data_r_valid_o);
      err_pend <= data_gnt_o && tgt_err;
      if (data_gnt_o) begin
        cur_idx <= tgt_idx;
        cur_err <= tgt_err;
      end
    end
endmodule
